// File: rtl/norm_shift_ctrl_if.sv
// Handshake and result bundle between the normaliser and its user.
interface norm_shift_ctrl_if #(
    parameter int WIDTH   = 40,
    parameter int SHIFT_W = 4
);
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic               busy;
    logic [WIDTH-1:0]   out_data;
    logic [SHIFT_W-1:0] out_shift;
    logic [SHIFT_W-1:0] out_div;
    logic               out_sat;
    logic               out_valid;

    modport master (
        output in_data, in_valid,
        input  in_ready, busy, out_data, out_shift, out_div, out_sat, out_valid
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, busy, out_data, out_shift, out_div, out_sat, out_valid
    );
endinterface

// File: rtl/norm_shift_ctrl.sv
// Normaliser for the sigma-delta frequency path: right-shifts a captured
// magnitude one bit per clock until the top HEADROOM bits are clear, then
// publishes the word, the shift count and the divider code DIV_BASE - shift.
module norm_shift_ctrl #(
    parameter int WIDTH      = 40,
    parameter int HEADROOM   = 12,
    parameter int SHIFT_W    = 4,
    parameter int MAX_SHIFT  = 15,
    parameter int DIV_BASE   = 12,
    parameter int AUTO_START = 1
) (
    input  logic              CLK67MHZ,
    input  logic              resetPort,
    norm_shift_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [SHIFT_W-1:0] MAX_CNT = SHIFT_W'(MAX_SHIFT);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHIFT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   prev_in_q, prev_in_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SHIFT_W-1:0] out_shift_q, out_shift_d;
    logic [SHIFT_W-1:0] out_div_q, out_div_d;
    logic               out_sat_q, out_sat_d;

    logic in_ready;
    logic change;
    logic start;
    logic headroom_ok;

    // Divider code for a given shift count, floored at zero.
    function automatic logic [SHIFT_W-1:0] div_code(input logic [SHIFT_W-1:0] shift);
        if (int'(shift) > DIV_BASE) begin
            return '0;
        end
        return SHIFT_W'(DIV_BASE - int'(shift));
    endfunction

    // Start qualification: value change in auto mode, handshake otherwise.
    always_comb begin
        in_ready    = (state_q == S_IDLE) && !resetPort;
        change      = (prev_in_q != bus.in_data);
        start       = (AUTO_START != 0) ? change : (bus.in_valid && in_ready);
        headroom_ok = (work_q[WIDTH-1 -: HEADROOM] == '0);
    end

    // Next-state and datapath update; a start overrides whatever SHIFT would do.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        prev_in_d   = bus.in_data;
        out_data_d  = out_data_q;
        out_shift_d = out_shift_q;
        out_div_d   = out_div_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            S_SHIFT: begin
                if (headroom_ok || (cnt_q == MAX_CNT)) begin
                    out_data_d  = work_q;
                    out_shift_d = cnt_q;
                    out_div_d   = div_code(cnt_q);
                    out_sat_d   = !headroom_ok;
                    state_d     = S_DONE;
                end else begin
                    work_d = work_q >> 1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A restart discards any result the aborted pass was about to publish.
        if (start) begin
            work_d      = bus.in_data;
            cnt_d       = '0;
            state_d     = S_SHIFT;
            out_data_d  = out_data_q;
            out_shift_d = out_shift_q;
            out_div_d   = out_div_q;
            out_sat_d   = out_sat_q;
        end
    end

    // State and result registers; reset clears everything including results.
    always_ff @(posedge CLK67MHZ) begin
        if (resetPort) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            prev_in_q   <= '0;
            out_data_q  <= '0;
            out_shift_q <= '0;
            out_div_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            prev_in_q   <= prev_in_d;
            out_data_q  <= out_data_d;
            out_shift_q <= out_shift_d;
            out_div_q   <= out_div_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = out_data_q;
    assign bus.out_shift = out_shift_q;
    assign bus.out_div   = out_div_q;
    assign bus.out_sat   = out_sat_q;

endmodule
